// File: rtl/fixed_seq_multi_pkg.sv
// Shared types and saturation helpers for the sequential fixed-point multiplier.
package fixflo_pkg;

    localparam int DEF_INT_W  = 8;
    localparam int DEF_FRAC_W = 8;
    localparam int MAX_W      = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN,
        DONE
    } state_e;

    function automatic logic [MAX_W-1:0] sat_max_uns(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

    function automatic logic [MAX_W-1:0] sat_max_pos(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w + 1);
    endfunction

    function automatic logic [MAX_W-1:0] sat_min_neg(input int w);
        logic [MAX_W-1:0] v;
        v = '0;
        v[w-1] = 1'b1;
        return v;
    endfunction

    // Clamp value for a w-bit result; callers cast down to w bits.
    function automatic logic [MAX_W-1:0] sat_value(input int w, input logic is_signed,
                                                   input logic neg);
        if (!is_signed) return sat_max_uns(w);
        else if (neg)   return sat_min_neg(w);
        else            return sat_max_pos(w);
    endfunction

endpackage

// File: rtl/fixed_seq_multi_if.sv
// Operand/result handshake bundle between producer, multiplier and consumer.
interface fixed_seq_multi_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   num1;
    logic [W-1:0]   num2;
    logic           signed_mode;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   result;
    logic [2*W-1:0] result_full;
    logic           overflow;
    logic           precision_lost;

    modport master (
        output in_valid, num1, num2, signed_mode, out_ready,
        input  in_ready, out_valid, result, result_full, overflow, precision_lost
    );

    modport slave (
        input  in_valid, num1, num2, signed_mode, out_ready,
        output in_ready, out_valid, result, result_full, overflow, precision_lost
    );
endinterface

// File: rtl/fixed_seq_multi_sign_mag.sv
// Conditional two's-complement negate: operand magnitude on the way in, product sign on the way out.
module fixed_sign_mag #(
    parameter int W = 16
) (
    input  logic         neg_i,
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);
    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign y_o = neg_i ? (~a_i + 1'b1) : a_i;
endmodule

// File: rtl/fixed_seq_multi.sv
// Radix-2 shift-add fixed-point multiplier, one multiplier bit per cycle,
// sign-magnitude core with optional saturation of the W-bit result.
module fixed_seq_multi
    import fixflo_pkg::*;
#(
    parameter int INT_W    = DEF_INT_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    fixed_seq_multi_if.slave bus
);
    localparam int W  = INT_W + FRAC_W;
    localparam int CW = $clog2(W);

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            mode_q, mode_d;
    logic            sign_q, sign_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    result_q, result_d;
    logic [2*W-1:0]  full_q, full_d;
    logic            ovf_q, ovf_d;
    logic            pl_q, pl_d;

    logic [W-1:0]    mag1, mag2;
    logic [2*W-1:0]  prod;
    logic [2*W-1:0]  partial;
    logic            ovf_u, ovf_s, ovf_w;
    logic [W-1:0]    res_w;
    logic [INT_W:0]  top_s;

    fixed_sign_mag #(.W(W)) u_mag1 (
        .neg_i (bus.signed_mode & bus.num1[W-1]),
        .a_i   (bus.num1),
        .y_o   (mag1)
    );

    fixed_sign_mag #(.W(W)) u_mag2 (
        .neg_i (bus.signed_mode & bus.num2[W-1]),
        .a_i   (bus.num2),
        .y_o   (mag2)
    );

    fixed_sign_mag #(.W(2*W)) u_neg (
        .neg_i (sign_q),
        .a_i   (acc_q),
        .y_o   (prod)
    );

    assign partial = {{W{1'b0}}, mcand_q} << cnt_q;

    // Signed overflow: the bits above the result MSB must all replicate its sign.
    assign top_s = prod[2*W-1:W+FRAC_W-1];
    assign ovf_u = |prod[2*W-1:W+FRAC_W];
    assign ovf_s = ~((&top_s) | ~(|top_s));
    assign ovf_w = mode_q ? ovf_s : ovf_u;
    assign res_w = (SATURATE && ovf_w) ? W'(sat_value(W, mode_q, sign_q))
                                       : prod[W+FRAC_W-1:FRAC_W];

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        sign_d   = sign_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        full_d   = full_q;
        ovf_d    = ovf_q;
        pl_d     = pl_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    mode_d   = bus.signed_mode;
                    sign_d   = bus.signed_mode & (bus.num1[W-1] ^ bus.num2[W-1]);
                    mcand_d  = mag1;
                    mplier_d = mag2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[cnt_q]) acc_d = acc_q + partial;
                if (cnt_q == CW'(W-1)) begin
                    cnt_d   = '0;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIN: begin
                result_d = res_w;
                full_d   = prod;
                ovf_d    = ovf_w;
                pl_d     = |prod[FRAC_W-1:0];
                state_d  = DONE;
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next state.
    assign in_ready_d  = (state_d == IDLE);
    assign out_valid_d = (state_d == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mode_q      <= 1'b0;
            sign_q      <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            full_q      <= '0;
            ovf_q       <= 1'b0;
            pl_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            mode_q      <= mode_d;
            sign_q      <= sign_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            pl_q        <= pl_d;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.result         = result_q;
    assign bus.result_full    = full_q;
    assign bus.overflow       = ovf_q;
    assign bus.precision_lost = pl_q;

endmodule

// File: tb/tb_fixed_seq_multi.sv
// Bench for fixed_seq_multi: wrapping and saturating instances driven in lockstep,
// checked against an integer-arithmetic product model.
module tb_fixed_seq_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        sm = 1'b0;
    logic [15:0] n1 = '0, n2 = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fixed_seq_multi_if #(.W(16)) ifw ();
    fixed_seq_multi_if #(.W(16)) ifs ();

    assign ifw.in_valid = in_valid;  assign ifs.in_valid = in_valid;
    assign ifw.out_ready = out_ready; assign ifs.out_ready = out_ready;
    assign ifw.signed_mode = sm;     assign ifs.signed_mode = sm;
    assign ifw.num1 = n1;            assign ifs.num1 = n1;
    assign ifw.num2 = n2;            assign ifs.num2 = n2;

    fixed_seq_multi #(.INT_W(8), .FRAC_W(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(ifw));
    fixed_seq_multi #(.INT_W(8), .FRAC_W(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(ifs));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Product computed as plain signed/unsigned integers, then read as Q8.8 / Q16.16.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic m,
                         input bit sat, output logic [15:0] r, output logic [31:0] f,
                         output logic o, output logic pl);
        longint va, vb, p, q;
        va = m ? longint'($signed(a)) : longint'(a);
        vb = m ? longint'($signed(b)) : longint'(b);
        p  = va * vb;
        q  = p >>> 8;
        f  = p[31:0];
        pl = (p[7:0] != 8'd0);
        o  = m ? (q > 32767 || q < -32768) : (q > 65535);
        r  = p[23:8];
        if (sat && o) r = !m ? 16'hFFFF : (p < 0 ? 16'h8000 : 16'h7FFF);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ifw.in_ready && n < 50) begin @(negedge clk); n++; end
        chk("ready_timeout", ifw.in_ready, 1);
    endtask

    task automatic check_fields(input string tag, input logic [15:0] a, input logic [15:0] b,
                                input logic m);
        logic [15:0] rw, rs;
        logic [31:0] f, fs;
        logic o, os, pl, pls;
        model(a, b, m, 1'b0, rw, f, o, pl);
        model(a, b, m, 1'b1, rs, fs, os, pls);
        chk({tag, "_valid"}, ifw.out_valid, 1);
        chk({tag, "_inrdy"}, ifw.in_ready, 0);
        chk({tag, "_res"}, ifw.result, rw);
        chk({tag, "_full"}, ifw.result_full, f);
        chk({tag, "_ovf"}, ifw.overflow, o);
        chk({tag, "_pl"}, ifw.precision_lost, pl);
        chk({tag, "_sres"}, ifs.result, rs);
        chk({tag, "_sfull"}, ifs.result_full, fs);
        chk({tag, "_sovf"}, ifs.overflow, os);
    endtask

    task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic m, input int hold);
        int lat = 0;
        wait_ready();
        in_valid = 1'b1; n1 = a; n2 = b; sm = m;
        @(negedge clk);
        in_valid = 1'b0;
        n1 = 16'($urandom); n2 = 16'($urandom); sm = 1'($urandom);
        chk({tag, "_rdydrop"}, ifw.in_ready, 0);
        while (!ifw.out_valid && lat < 100) begin @(negedge clk); lat++; end
        chk({tag, "_lat"}, lat, 17);
        check_fields(tag, a, b, m);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n1 = 16'($urandom); n2 = 16'($urandom);
            check_fields({tag, "_hold"}, a, b, m);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, ifw.out_valid, 0);
        chk({tag, "_drain_rdy"}, ifw.in_ready, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, ifw.out_valid, 0);
        chk({tag, "_rdy"}, ifw.in_ready, 0);
        chk({tag, "_res"}, ifw.result, 0);
        chk({tag, "_full"}, ifw.result_full, 0);
        chk({tag, "_ovf"}, ifw.overflow, 0);
        chk({tag, "_pl"}, ifw.precision_lost, 0);
        chk({tag, "_sres"}, ifs.result, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rdy_after_release", ifw.in_ready, 0);
        @(negedge clk);
        chk("rdy_first_edge", ifw.in_ready, 1);

        run_txn("u_2p5x3", 16'h0280, 16'h0300, 1'b0, 0);
        run_txn("u_lsb", 16'h0001, 16'h0001, 1'b0, 0);
        run_txn("u_ovf", 16'h8000, 16'h0200, 1'b0, 1);
        run_txn("s_neg", 16'hFE80, 16'h0200, 1'b1, 0);
        run_txn("s_minmin", 16'h8000, 16'h8000, 1'b1, 0);
        run_txn("s_zero", 16'h0000, 16'h8000, 1'b1, 0);
        run_txn("s_negovf", 16'h8000, 16'h7FFF, 1'b1, 0);
        run_txn("bp5", 16'hFF01, 16'h0123, 1'b1, 5);

        for (int k = 0; k < 20; k++) begin
            ra = 16'($urandom);
            rb = (k % 3 == 0) ? 16'($urandom_range(0, 1023)) : 16'($urandom);
            run_txn("rand", ra, rb, 1'($urandom), $urandom_range(0, 2));
        end

        // Abort a transaction partway through the shift-add loop.
        run_txn("pre_rst", 16'h7F81, 16'h0303, 1'b0, 0);
        wait_ready();
        in_valid = 1'b1; n1 = 16'h1234; n2 = 16'h5678; sm = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_rdy_release", ifw.in_ready, 0);
        @(negedge clk);
        chk("midrst_rdy_edge", ifw.in_ready, 1);
        chk("midrst_no_valid", ifw.out_valid, 0);
        run_txn("post_rst", 16'hFD40, 16'hFE00, 1'b1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/fixed_seq_multi.md
Name: fixed_seq_multi

Overview:
- Sequential, parametrised successor to the combinational 16-bit fixed-point multiplier.
- Multiplies two INT_W.FRAC_W fixed-point operands with a radix-2 shift-add datapath, one multiplier bit per cycle.
- Selects unsigned or two's-complement per transaction, with optional saturation.
- Sits between producer and consumer logic on valid/ready handshakes; trades latency for area in the fixed-point arithmetic path.

Parameters:
- INT_W, 8, integer bits of operands and result.
- FRAC_W, 8, fraction bits of operands and result.
- SATURATE, 0, 1 = clamp result on overflow; 0 = wrap (truncated bits).
- Derived localparam W = INT_W+FRAC_W; not overridable.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept operands.
- num1  input  W  multiplicand.
- num2  input  W  multiplier.
- signed_mode  input  1  1 = two's complement operands, 0 = unsigned.
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer takes result.
- result  output  W  product, same INT_W.FRAC_W format.
- result_full  output  2W  exact full-width product (2INT_W.2FRAC_W).
- overflow  output  1  product not representable in W bits of selected mode.
- precision_lost  output  1  any nonzero bit below result LSB.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; in_ready, out_valid, result, result_full, overflow and precision_lost all 0.
  - A transaction in flight is discarded.
  - in_ready is registered and rises on the first clk edge after rst_n deasserts.
- States: IDLE -> CALC -> FIN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (accept edge T0): latch signed_mode.
  - Latch magnitudes |num1| and |num2|; magnitude conversion applies only in signed mode. Magnitude of -2^(W-1) is 2^(W-1) and fits in W bits unsigned.
  - Latch product sign = msb1^msb2 (signed only).
  - Clear accumulator (2W) and bit counter; go to CALC; in_ready drops at T0.
- CALC:
  - Iterate W cycles (edges T1..TW).
  - At step i: if multiplier bit i is 1, accumulator += multiplicand_magnitude << i.
  - Counter wraps exactly at W-1; the transition to FIN happens on the edge of the last step.
- FIN (edge TW+1):
  - Negate accumulator if product sign=1; zero product stays 0.
  - Register result_full = P.
  - result = P[W+FRAC_W-1:FRAC_W].
  - precision_lost = |P[FRAC_W-1:0].
  - overflow:
    - unsigned: |P[2W-1:W+FRAC_W].
    - signed: bits P[2W-1:W+FRAC_W-1] not all equal.
  - Saturation: if SATURATE=1 and overflow, result = all-ones (unsigned), or max positive / min negative chosen by product sign (signed). result_full is never saturated.
  - out_valid=1 from TW+1; latency accept-to-out_valid = W+1 cycles.
- DONE:
  - Outputs held stable while out_valid&~out_ready; in_ready=0.
  - On out_valid&out_ready: out_valid clears and the FSM returns to IDLE.
  - in_ready is 1 the following cycle; no accept in the same cycle as a result drain.
- Flags hold their last values between transactions; they are meaningful only while out_valid=1.
- Input changes while not in IDLE are ignored.
- in_valid held high continuously yields one transaction per W+3 cycles when out_ready=1.

Decomposition:
- Shared package fixflo_pkg:
  - state enum (IDLE, CALC, FIN, DONE);
  - default INT_W/FRAC_W constants;
  - saturation-value helper functions.
- One natural sub-module: fixed_sign_mag (parametrised W). It handles two's-complement to sign-magnitude conversion and back, and is reused for operand magnitude and result negation.

Test Plan (INT_W=8, FRAC_W=8):
- Unsigned 0x0280 (2.5) × 0x0300 (3.0) -> result 0x0780, overflow 0, precision_lost 0, out_valid exactly 17 cycles after accept.
- Unsigned 0x0001 × 0x0001 -> result 0x0000, result_full 0x00000001, precision_lost 1, overflow 0.
- Unsigned 0x8000 × 0x0200 -> overflow 1; result 0x0000 with SATURATE=0, 0xFFFF with SATURATE=1; result_full 0x01000000.
- Signed 0xFE80 (-1.5) × 0x0200 (2.0) -> result 0xFD00, result_full 0xFFFD0000, overflow 0.
- Signed 0x8000 × 0x8000 -> overflow 1; SATURATE=1 gives result 0x7FFF. Also signed 0x0000 × 0x8000 -> result 0x0000, overflow 0.
- Backpressure and reset:
  - Hold out_ready low 5 cycles in DONE -> outputs stable, in_ready 0.
  - Assert rst_n low mid-CALC -> all outputs 0 immediately, in_ready 1 one edge after release.
  - A new transaction then completes correctly.
